irq_controller: RTL and testbench

Interrupt controller driving the PC's `interrupt_signal` input. It latches rising edges on up to `NUM_SOURCES` external request lines into a pending register and masks them through a CPU-writable mask. It dispatches the highest-priority request as a single-cycle pulse, then tracks the fixed-length ISR by counting `exec2` pulses so that no new request is issued until the PC has resumed the main program.

---
 rtl/irq_pkg.sv | 25 ++
 rtl/irq_priority_encoder.sv | 29 ++
 rtl/irq_controller.sv | 176 +++++++++++++++++
 tb/tb_irq_controller.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// -----------------------------------------------------------------------------
// irq_pkg
// Shared types and constants for the interrupt controller.
//   irq_state_t : dispatch/service state machine encoding (also visible in
//                 STATUS[1:0]).
//   CFG_*       : register-select values for cfg_addr.
//   SVC_CNT_W   : width of the ISR progress counter (ISR_LENGTH <= 15).
// -----------------------------------------------------------------------------
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        ENTRY   = 2'd2,
        SERVICE = 2'd3
    } irq_state_t;

    localparam logic [1:0] CFG_MASK    = 2'd0;
    localparam logic [1:0] CFG_PENDING = 2'd1;
    localparam logic [1:0] CFG_CAUSE   = 2'd2;
    localparam logic [1:0] CFG_STATUS  = 2'd3;

    localparam int SVC_CNT_W = 4;

endpackage

// File: rtl/irq_priority_encoder.sv
// -----------------------------------------------------------------------------
// irq_priority_encoder
// Combinational fixed-priority encoder: reports the index of the lowest set
// bit of req (bit 0 has highest priority) and whether any bit is set.
//   req   in   WIDTH  request vector
//   idx   out  IDX_W  index of lowest set bit (0 when none set)
//   valid out  1      at least one bit of req is set
// -----------------------------------------------------------------------------
module irq_priority_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             valid
);

    always_comb begin
        idx   = '0;
        valid = |req;
        // Scan downward so the lowest set index is the last one written.
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
// Interrupt controller for the PC's interrupt_signal input. Rising edges on
// irq_in are latched into PENDING, gated by MASK, and the lowest-index enabled
// request is dispatched as a one-cycle pulse. The controller then follows the
// fixed-length ISR by counting exec2 strobes and only re-arms once the PC has
// returned to the main program.
//   clk              in   1            system clock, posedge
//   reset            in   1            synchronous, active-low
//   exec2            in   1            CPU final-execute-cycle strobe
//   irq_in           in   NUM_SOURCES  level request lines (clk-synchronous)
//   cfg_write        in   1            register write strobe
//   cfg_addr         in   2            0 MASK, 1 PENDING, 2 CAUSE, 3 STATUS
//   cfg_wdata        in   32           write data
//   cfg_rdata        out  32           combinational read of cfg_addr
//   interrupt_signal out  1            single-cycle dispatch pulse
//   in_service       out  1            high from dispatch until ISR return
//   cause_id         out  ID_W         index of the last dispatched source
// -----------------------------------------------------------------------------
module irq_controller
    import irq_pkg::*;
#(
    parameter  int NUM_SOURCES = 8,
    parameter  int ISR_LENGTH  = 10,
    localparam int ID_W        = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   exec2,
    input  logic [NUM_SOURCES-1:0] irq_in,
    input  logic                   cfg_write,
    input  logic [1:0]             cfg_addr,
    input  logic [31:0]            cfg_wdata,
    output logic [31:0]            cfg_rdata,
    output logic                   interrupt_signal,
    output logic                   in_service,
    output logic [ID_W-1:0]        cause_id
);

    localparam logic [SVC_CNT_W-1:0] LAST_SVC = SVC_CNT_W'(ISR_LENGTH - 1);

    irq_state_t             state;
    irq_state_t             next_state;
    logic [NUM_SOURCES-1:0] mask;
    logic [NUM_SOURCES-1:0] pending;
    logic [NUM_SOURCES-1:0] irq_prev;
    logic [SVC_CNT_W-1:0]   svc_cnt;
    logic                   cause_valid;

    logic [NUM_SOURCES-1:0] armed;
    logic [NUM_SOURCES-1:0] edges;
    logic [NUM_SOURCES-1:0] w1c_clear;
    logic [NUM_SOURCES-1:0] dispatch_clear;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_valid;
    logic                   dispatch;
    logic                   svc_clear;
    logic                   svc_inc;
    logic                   unused_wdata;

    assign armed          = pending & mask;
    assign edges          = irq_in & ~irq_prev;
    assign w1c_clear      = (cfg_write && cfg_addr == CFG_PENDING)
                            ? cfg_wdata[NUM_SOURCES-1:0] : '0;
    assign dispatch_clear = dispatch ? (NUM_SOURCES'(1) << pick_idx) : '0;
    assign in_service     = (state != IDLE);
    assign unused_wdata   = ^cfg_wdata[31:NUM_SOURCES];

    irq_priority_encoder #(
        .WIDTH (NUM_SOURCES),
        .IDX_W (ID_W)
    ) u_pick (
        .req   (armed),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // NOTE: reset is synchronous here, so it is just another condition
    // evaluated at the clock edge rather than an entry in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave a value held and infer a latch.
    always_comb begin
        next_state       = state;
        dispatch         = 1'b0;
        svc_clear        = 1'b0;
        svc_inc          = 1'b0;
        interrupt_signal = 1'b0;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    dispatch   = 1'b1;
                    next_state = REQUEST;
                end
            end
            REQUEST: begin
                // The PC ignores exec2 while the pulse is high, so the pulse
                // is held off until exec2 is quiet. Gating with reset drops a
                // pulse that would otherwise escape during the reset cycle.
                if (!exec2) begin
                    interrupt_signal = reset;
                    next_state       = ENTRY;
                end
            end
            ENTRY: begin
                // This exec2 is the PC's redirect into the ISR.
                if (exec2) begin
                    svc_clear  = 1'b1;
                    next_state = SERVICE;
                end
            end
            SERVICE: begin
                if (exec2) begin
                    svc_inc = 1'b1;
                    if (svc_cnt == LAST_SVC) begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // here samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mask        <= '0;
            pending     <= '0;
            irq_prev    <= '0;
            svc_cnt     <= '0;
            cause_id    <= '0;
            cause_valid <= 1'b0;
        end else begin
            irq_prev <= irq_in;
            // Clears are applied before the OR so a fresh edge always wins.
            pending  <= (pending & ~w1c_clear & ~dispatch_clear) | edges;
            if (cfg_write && cfg_addr == CFG_MASK) begin
                mask <= cfg_wdata[NUM_SOURCES-1:0];
            end
            if (dispatch) begin
                cause_id    <= pick_idx;
                cause_valid <= 1'b1;
            end
            if (svc_clear) begin
                svc_cnt <= '0;
            end else if (svc_inc) begin
                svc_cnt <= svc_cnt + SVC_CNT_W'(1);
            end
        end
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            CFG_MASK:    cfg_rdata[NUM_SOURCES-1:0] = mask;
            CFG_PENDING: cfg_rdata[NUM_SOURCES-1:0] = pending;
            CFG_CAUSE: begin
                cfg_rdata[31]       = cause_valid;
                cfg_rdata[ID_W-1:0] = cause_id;
            end
            default: begin
                cfg_rdata[1:0]  = state;
                cfg_rdata[11:8] = svc_cnt;
            end
        endcase
    end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;

    localparam int NS  = 8;
    localparam int ISR = 10;

    // Phases of a dispatch as seen from outside: waiting, pulse owed,
    // waiting for the redirect, running the ISR.
    localparam int PH_IDLE  = 0;
    localparam int PH_REQ   = 1;
    localparam int PH_ENTRY = 2;
    localparam int PH_SERV  = 3;

    logic          clk;
    logic          reset;
    logic          exec2;
    logic [NS-1:0] irq_in;
    logic          cfg_write;
    logic [1:0]    cfg_addr;
    logic [31:0]   cfg_wdata;
    logic [31:0]   cfg_rdata;
    logic          interrupt_signal;
    logic          in_service;
    logic [2:0]    cause_id;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    logic [NS-1:0] m_mask;
    logic [NS-1:0] m_pending;
    logic [NS-1:0] m_prev;
    int            m_phase;
    int            m_left;   // exec2 strobes the running ISR still owes
    int            m_cause;
    bit            m_valid;

    irq_controller #(
        .NUM_SOURCES (NS),
        .ISR_LENGTH  (ISR)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .exec2            (exec2),
        .irq_in           (irq_in),
        .cfg_write        (cfg_write),
        .cfg_addr         (cfg_addr),
        .cfg_wdata        (cfg_wdata),
        .cfg_rdata        (cfg_rdata),
        .interrupt_signal (interrupt_signal),
        .in_service       (in_service),
        .cause_id         (cause_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_mask    = '0;
        m_pending = '0;
        m_prev    = '0;
        m_phase   = PH_IDLE;
        m_left    = 0;
        m_cause   = 0;
        m_valid   = 0;
    endtask

    // Advance the model by one clock edge using the inputs presented this cycle.
    task automatic model_update();
        logic [NS-1:0] newp;
        int            pick;
        if (!reset) begin
            model_reset();
            return;
        end
        newp = m_pending;
        if (cfg_write && cfg_addr == 2'd1) newp = newp & ~cfg_wdata[NS-1:0];
        case (m_phase)
            PH_IDLE: begin
                pick = -1;
                for (int i = 0; i < NS; i++) begin
                    if (m_pending[i] && m_mask[i]) begin
                        pick = i;
                        break;
                    end
                end
                if (pick >= 0) begin
                    m_cause    = pick;
                    m_valid    = 1;
                    newp[pick] = 1'b0;
                    m_phase    = PH_REQ;
                end
            end
            PH_REQ:   if (!exec2) m_phase = PH_ENTRY;
            PH_ENTRY: if (exec2) begin
                m_phase = PH_SERV;
                m_left  = ISR;
            end
            default: if (exec2) begin
                m_left--;
                if (m_left == 0) m_phase = PH_IDLE;
            end
        endcase
        newp      = newp | (irq_in & ~m_prev);
        m_pending = newp;
        if (cfg_write && cfg_addr == 2'd0) m_mask = cfg_wdata[NS-1:0];
        m_prev = irq_in;
    endtask

    // Compare every output against the model, #1 after the falling edge.
    task automatic settle();
        logic [31:0] exp;
        logic [31:0] keep;
        #1;
        check("irq_pulse", 32'(interrupt_signal),
              32'(reset && m_phase == PH_REQ && !exec2));
        check("in_service", 32'(in_service), 32'(m_phase != PH_IDLE));
        check("cause_id", 32'(cause_id), 32'(m_cause));
        keep = 32'hFFFF_FFFF;
        case (cfg_addr)
            2'd0: exp = 32'(m_mask);
            2'd1: exp = 32'(m_pending);
            2'd2: exp = {m_valid, 28'd0, 3'(m_cause)};
            default: begin
                exp = 32'(m_phase);
                if (m_phase == PH_SERV) exp[11:8] = 4'(ISR - m_left);
                else keep = 32'hFFFF_F0FF;
            end
        endcase
        check("cfg_rdata", cfg_rdata & keep, exp & keep);
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        cfg_write = 1'b1;
        cfg_addr  = a;
        cfg_wdata = d;
        cycle();
        cfg_write = 1'b0;
    endtask

    // Drive random exec2 until the model says the ISR has returned.
    task automatic run_isr(input int gap);
        int budget;
        budget = 500;
        while (m_phase != PH_IDLE && budget > 0) begin
            exec2 = ($urandom_range(0, gap) == 0);
            cycle();
            budget--;
        end
        exec2 = 1'b0;
        check("isr_return", 32'(in_service), 32'd0);
    endtask

    task automatic check_cleared(input string tag);
        for (int a = 0; a < 4; a++) begin
            cfg_addr = 2'(a);
            settle();
            check(tag, cfg_rdata, 32'd0);
            tick();
        end
    endtask

    initial begin
        reset     = 1'b0;
        exec2     = 1'b0;
        irq_in    = '0;
        cfg_write = 1'b0;
        cfg_addr  = 2'd0;
        cfg_wdata = '0;
        model_reset();
        @(negedge clk);
        tick();
        cycle();
        reset = 1'b1;

        // Reset state
        check("reset_pulse", 32'(interrupt_signal), 32'd0);
        check("reset_in_service", 32'(in_service), 32'd0);
        check("reset_cause_id", 32'(cause_id), 32'd0);
        check_cleared("reset_regs");

        // Masked edge, then enable it
        irq_in = 8'h08;
        cycle();
        irq_in = 8'h00;
        cfg_addr = 2'd1;
        settle();
        check("masked_pending", cfg_rdata, 32'h08);
        check("masked_no_pulse", 32'(interrupt_signal), 32'd0);
        tick();
        repeat (3) cycle();
        write_reg(2'd0, 32'h08);
        cfg_addr = 2'd1;
        settle();
        check("unmask_decide", 32'(interrupt_signal), 32'd0);
        tick();
        settle();
        check("unmask_pulse", 32'(interrupt_signal), 32'd1);
        check("unmask_cause", 32'(cause_id), 32'd3);
        check("unmask_pending", cfg_rdata, 32'h00);
        tick();
        run_isr(2);

        // Simultaneous edges: lower index first
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h24;
        cycle();
        cycle();
        settle();
        check("simul_first_pulse", 32'(interrupt_signal), 32'd1);
        check("simul_first_cause", 32'(cause_id), 32'd2);
        tick();
        run_isr(1);
        cycle();
        settle();
        check("simul_second_pulse", 32'(interrupt_signal), 32'd1);
        check("simul_second_cause", 32'(cause_id), 32'd5);
        tick();
        run_isr(1);

        // exec2 collision while a pulse is owed
        irq_in = 8'h25;
        cycle();
        cycle();
        exec2 = 1'b1;
        settle();
        check("collide_hold0", 32'(interrupt_signal), 32'd0);
        tick();
        settle();
        check("collide_hold1", 32'(interrupt_signal), 32'd0);
        tick();
        exec2 = 1'b0;
        settle();
        check("collide_pulse", 32'(interrupt_signal), 32'd1);
        check("collide_cause", 32'(cause_id), 32'd0);
        tick();
        settle();
        check("collide_single", 32'(interrupt_signal), 32'd0);
        tick();
        run_isr(1);

        // Service length, with a new edge arriving mid-service
        irq_in = 8'h00;
        cycle();
        irq_in = 8'h02;
        cycle();
        cycle();
        cycle();
        exec2 = 1'b1;
        cycle();
        cfg_addr = 2'd1;
        for (int k = 0; k < ISR; k++) begin
            exec2 = 1'b0;
            cycle();
            if (k == 3) irq_in = 8'h42;
            exec2 = 1'b1;
            settle();
            check("svc_still_busy", 32'(in_service), 32'd1);
            tick();
        end
        exec2 = 1'b0;
        settle();
        check("svc_returned", 32'(in_service), 32'd0);
        check("svc_held_pending", cfg_rdata, 32'h40);
        tick();
        settle();
        check("svc_redispatch", 32'(interrupt_signal), 32'd1);
        check("svc_redispatch_cause", 32'(cause_id), 32'd6);
        tick();
        run_isr(2);

        // W1C racing a fresh edge: set wins
        write_reg(2'd0, 32'h00);
        irq_in = 8'h00;
        cycle();
        irq_in    = 8'h01;
        cfg_write = 1'b1;
        cfg_addr  = 2'd1;
        cfg_wdata = 32'h01;
        cycle();
        cfg_write = 1'b0;
        settle();
        check("w1c_race_set_wins", cfg_rdata, 32'h01);
        tick();
        write_reg(2'd1, 32'h01);
        settle();
        check("w1c_clears", cfg_rdata, 32'h00);
        tick();

        // Reset during SERVICE
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h00;
        cycle();
        irq_in = 8'h10;
        cycle();
        cycle();
        cycle();
        exec2 = 1'b1;
        cycle();
        cycle();
        exec2 = 1'b0;
        cfg_addr = 2'd3;
        settle();
        check("pre_reset_status", cfg_rdata, 32'h0000_0103);
        tick();
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        check("post_reset_in_service", 32'(in_service), 32'd0);
        check("post_reset_pulse", 32'(interrupt_signal), 32'd0);
        irq_in = 8'h00;
        check_cleared("post_reset_regs");

        // Reset while a pulse is owed: it must be dropped
        write_reg(2'd0, 32'hFF);
        irq_in = 8'h80;
        cycle();
        cycle();
        reset = 1'b0;
        settle();
        check("reset_drops_pulse", 32'(interrupt_signal), 32'd0);
        tick();
        reset = 1'b1;
        settle();
        check("reset_back_idle", 32'(in_service), 32'd0);
        tick();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            reset     = ($urandom_range(0, 299) != 0);
            exec2     = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 3) == 0)
                irq_in = irq_in ^ NS'(1 << $urandom_range(0, NS - 1));
            cfg_write = ($urandom_range(0, 7) == 0);
            cfg_addr  = 2'($urandom_range(0, 3));
            cfg_wdata = $urandom;
            cycle();
        end
        reset     = 1'b1;
        cfg_write = 1'b0;
        exec2     = 1'b0;
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
